// File: rtl/queue_access_arbiter_if.sv
// Producer/consumer/queue-port bundle shared by the arbiter and its neighbours.
// master = arbiter side, slave = producers, consumer and queue side.
interface queue_access_arbiter_if #(
    parameter int DW = 4,
    parameter int NP = 2
);
    logic [NP-1:0]    wr_req;
    logic [NP*DW-1:0] wr_data;
    logic [NP-1:0]    wr_gnt;
    logic             rd_req;
    logic             rd_gnt;
    logic             rd_valid;
    logic [DW-1:0]    rd_data;
    logic             q_en;
    logic             q_rw;
    logic [DW-1:0]    q_din;
    logic             q_empty;
    logic             q_full;
    logic [DW-1:0]    q_dout;

    modport master (
        input  wr_req, wr_data, rd_req, q_empty, q_full, q_dout,
        output wr_gnt, rd_gnt, rd_valid, rd_data, q_en, q_rw, q_din
    );

    modport slave (
        output wr_req, wr_data, rd_req, q_empty, q_full, q_dout,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, q_en, q_rw, q_din
    );
endinterface

// File: rtl/queue_access_arbiter.sv
// Single-port queue arbiter: round-robin producers vs. one consumer, one op per 3 cycles.
// Decision in IDLE, grant/op in ISSUE (+1), read data valid in SETTLE (+2); requesters simply wait.
module queue_access_arbiter #(
    parameter int DW = 4,
    parameter int NP = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    queue_access_arbiter_if.master bus
);
    localparam int IW = $clog2(NP);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

    state_t          state_q, state_d;
    logic            op_q, op_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            prefer_read_q, prefer_read_d;
    logic            q_en_q, q_en_d;
    logic            q_rw_q, q_rw_d;
    logic [DW-1:0]   q_din_q, q_din_d;
    logic [NP-1:0]   wr_gnt_q, wr_gnt_d;
    logic            rd_gnt_q, rd_gnt_d;
    logic            rd_valid_q, rd_valid_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;

    logic            found;
    logic [IW-1:0]   wr_win;
    logic            wr_elig, rd_elig;

    always_comb begin
        found  = 1'b0;
        wr_win = '0;
        for (int k = 0; k < NP; k++) begin
            if (!found && bus.wr_req[(int'(rr_ptr_q) + k) % NP]) begin
                found  = 1'b1;
                wr_win = IW'((int'(rr_ptr_q) + k) % NP);
            end
        end
    end

    assign wr_elig = (|bus.wr_req) && !bus.q_full;
    assign rd_elig = bus.rd_req && !bus.q_empty;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        win_d         = win_q;
        rr_ptr_d      = rr_ptr_q;
        prefer_read_d = prefer_read_q;
        q_en_d        = 1'b0;
        q_rw_d        = 1'b0;
        q_din_d       = '0;
        wr_gnt_d      = '0;
        rd_gnt_d      = 1'b0;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        case (state_q)
            IDLE: begin
                if (wr_elig || rd_elig) begin
                    op_d    = wr_elig && !(rd_elig && prefer_read_q);
                    win_d   = wr_win;
                    state_d = ISSUE;
                    q_en_d  = 1'b1;
                    q_rw_d  = op_d;
                    if (op_d) begin
                        q_din_d  = bus.wr_data[int'(wr_win)*DW +: DW];
                        wr_gnt_d = {{(NP-1){1'b0}}, 1'b1} << wr_win;
                    end else begin
                        rd_gnt_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d    = SETTLE;
                rd_valid_d = !op_q;
            end
            SETTLE: begin
                state_d       = IDLE;
                prefer_read_d = op_q;
                if (op_q) begin
                    rr_ptr_d = (int'(win_q) == NP-1) ? '0 : win_q + 1'b1;
                end else begin
                    rd_data_d = bus.q_dout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= 1'b0;
            win_q         <= '0;
            rr_ptr_q      <= '0;
            prefer_read_q <= 1'b0;
            q_en_q        <= 1'b0;
            q_rw_q        <= 1'b0;
            q_din_q       <= '0;
            wr_gnt_q      <= '0;
            rd_gnt_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            win_q         <= win_d;
            rr_ptr_q      <= rr_ptr_d;
            prefer_read_q <= prefer_read_d;
            q_en_q        <= q_en_d;
            q_rw_q        <= q_rw_d;
            q_din_q       <= q_din_d;
            wr_gnt_q      <= wr_gnt_d;
            rd_gnt_q      <= rd_gnt_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // The queue only presents the word during SETTLE, so rd_data passes it through
    // while rd_valid is high and holds the captured copy afterwards.
    assign bus.rd_data  = rd_valid_q ? bus.q_dout : rd_data_q;
    assign bus.q_en     = q_en_q;
    assign bus.q_rw     = q_rw_q;
    assign bus.q_din    = q_din_q;
    assign bus.wr_gnt   = wr_gnt_q;
    assign bus.rd_gnt   = rd_gnt_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_queue_access_arbiter.sv
// Bench for queue_access_arbiter: queue model, transaction-level reference model, directed tests.
module tb_queue_access_arbiter;
    localparam int DW = 4;
    localparam int NP = 2;
    localparam int QD = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic force_full = 1'b0;
    logic force_empty = 1'b0;
    int   vectors = 0;
    int   fails = 0;

    queue_access_arbiter_if #(.DW(DW), .NP(NP)) bus();

    queue_access_arbiter #(.DW(DW), .NP(NP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural single-port queue that the arbiter drives.
    logic [DW-1:0] qmem [QD];
    int            qh = 0, qt = 0, qc = 0;
    logic [DW-1:0] qdout = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            qh <= 0; qt <= 0; qc <= 0; qdout <= '0;
        end else if (bus.q_en) begin
            if (bus.q_rw && qc < QD) begin
                qmem[qt] <= bus.q_din;
                qt <= (qt + 1) % QD;
                qc <= qc + 1;
            end else if (!bus.q_rw && qc > 0) begin
                qdout <= qmem[qh];
                qh <= (qh + 1) % QD;
                qc <= qc - 1;
            end
        end
    end

    assign bus.q_full  = (qc == QD) || force_full;
    assign bus.q_empty = (qc == 0) || force_empty;
    assign bus.q_dout  = qdout;

    // Reference model: an operation is a 3-cycle slot (decide, issue, settle);
    // expected read data comes from a shadow list of everything written.
    function automatic int first_req(input logic [NP-1:0] req, input int rr);
        for (int k = 0; k < NP; k++)
            if (req[(rr + k) % NP]) return (rr + k) % NP;
        return 0;
    endfunction

    int            m_phase = 0;
    logic          m_op = 1'b0;
    int            m_win = 0;
    int            m_rr = 0;
    logic          m_pref = 1'b0;
    logic [DW-1:0] m_fifo [$];
    logic          e_qen = 1'b0, e_rw = 1'b0, e_rg = 1'b0, e_rv = 1'b0;
    logic [DW-1:0] e_din = '0, e_rd = '0;
    logic [NP-1:0] e_wg = '0;

    always @(posedge clk or posedge reset) begin
        logic wr_ok, rd_ok, op;
        int   w;
        logic [DW-1:0] d;
        if (reset) begin
            m_phase <= 0; m_op <= 1'b0; m_win <= 0; m_rr <= 0; m_pref <= 1'b0;
            m_fifo.delete();
            e_qen <= 1'b0; e_rw <= 1'b0; e_rg <= 1'b0; e_rv <= 1'b0;
            e_din <= '0; e_rd <= '0; e_wg <= '0;
        end else begin
            e_qen <= 1'b0; e_rw <= 1'b0; e_rg <= 1'b0; e_rv <= 1'b0;
            e_din <= '0; e_wg <= '0;
            if (m_phase == 0) begin
                wr_ok = (|bus.wr_req) && !bus.q_full;
                rd_ok = bus.rd_req && !bus.q_empty;
                if (wr_ok || rd_ok) begin
                    op = wr_ok && !(rd_ok && m_pref);
                    w  = first_req(bus.wr_req, m_rr);
                    m_op <= op; m_win <= w; m_phase <= 1;
                    e_qen <= 1'b1; e_rw <= op;
                    if (op) begin
                        d = bus.wr_data[w*DW +: DW];
                        m_fifo.push_back(d);
                        e_din <= d;
                        e_wg <= NP'(1 << w);
                    end else begin
                        e_rg <= 1'b1;
                    end
                end
            end else if (m_phase == 1) begin
                m_phase <= 2;
                if (!m_op) begin
                    e_rv <= 1'b1;
                    e_rd <= (m_fifo.size() > 0) ? m_fifo.pop_front() : '0;
                end
            end else begin
                m_phase <= 0;
                m_pref <= m_op;
                if (m_op) m_rr <= (m_win + 1) % NP;
            end
        end
    end

    always @(negedge clk) begin
        chk("q_en", bus.q_en, e_qen);
        chk("wr_gnt", bus.wr_gnt, e_wg);
        chk("rd_gnt", bus.rd_gnt, e_rg);
        chk("rd_valid", bus.rd_valid, e_rv);
        chk("rd_data", bus.rd_data, e_rd);
        if (e_qen) begin
            chk("q_rw", bus.q_rw, e_rw);
            chk("q_din", bus.q_din, e_din);
        end
    end

    task automatic wait_en(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.q_en && n < 30);
        chk("q_en_timeout", bus.q_en, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [NP-1:0] rr_exp [4];
    logic [DW-1:0] rr_din [4];
    logic          fr_rw  [4];

    initial begin
        int n;
        logic [DW-1:0] rd_exp;
        bus.wr_req = '0; bus.wr_data = '0; bus.rd_req = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_q_en", bus.q_en, 0);
        chk("rst_wr_gnt", bus.wr_gnt, 0);
        chk("rst_rd_gnt", bus.rd_gnt, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("idle_q_en", bus.q_en, 0);
        end

        // Reset asserted during ISSUE kills the operation immediately.
        bus.wr_data = 8'h0A; bus.wr_req = 2'b01;
        wait_en(n);
        chk("pre_rst_gnt", bus.wr_gnt, 2'b01);
        reset = 1'b1;
        #1;
        chk("mid_rst_q_en", bus.q_en, 0);
        chk("mid_rst_wr_gnt", bus.wr_gnt, 0);
        chk("mid_rst_rd_gnt", bus.rd_gnt, 0);
        chk("mid_rst_rd_valid", bus.rd_valid, 0);
        bus.wr_req = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single write then read.
        bus.wr_data = 8'h0A; bus.wr_req = 2'b01;
        @(negedge clk);
        chk("wr1_gnt", bus.wr_gnt, 2'b01);
        chk("wr1_q_en", bus.q_en, 1);
        chk("wr1_q_rw", bus.q_rw, 1);
        chk("wr1_q_din", bus.q_din, 4'b1010);
        bus.wr_req = '0;
        bus.rd_req = 1'b1;
        wait_en(n);
        chk("rd1_gnt", bus.rd_gnt, 1);
        chk("rd1_q_rw", bus.q_rw, 0);
        bus.rd_req = 1'b0;
        @(negedge clk);
        chk("rd1_valid", bus.rd_valid, 1);
        chk("rd1_data", bus.rd_data, 4'b1010);
        @(negedge clk);
        chk("rd1_valid_drop", bus.rd_valid, 0);
        chk("rd1_data_hold", bus.rd_data, 4'b1010);

        // Round-robin between two producers.
        pulse_reset();
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        rr_din[0] = 4'b1100; rr_din[1] = 4'b0011; rr_din[2] = 4'b1100; rr_din[3] = 4'b0011;
        bus.wr_data = {4'b0011, 4'b1100}; bus.wr_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_en(n);
            chk("rr_gnt", bus.wr_gnt, rr_exp[i]);
            chk("rr_din", bus.q_din, rr_din[i]);
            if (i > 0) chk("rr_spacing", n, 3);
        end
        bus.wr_req = '0;

        // Read/write fairness alternation.
        pulse_reset();
        fr_rw[0] = 1'b1; fr_rw[1] = 1'b0; fr_rw[2] = 1'b1; fr_rw[3] = 1'b0;
        bus.wr_data = 8'h05; bus.wr_req = 2'b01; bus.rd_req = 1'b1;
        rd_exp = 4'h5;
        for (int i = 0; i < 4; i++) begin
            wait_en(n);
            chk("fair_rw", bus.q_rw, fr_rw[i]);
            if (i == 3) begin
                bus.wr_req = '0; bus.rd_req = 1'b0;
            end
            if (fr_rw[i]) begin
                bus.wr_data = 8'h06;
            end else begin
                @(negedge clk);
                chk("fair_rd_data", bus.rd_data, rd_exp);
                rd_exp = 4'h6;
            end
        end

        // Full flag blocks writes; release grants within 2 cycles.
        repeat (3) @(negedge clk);
        force_full = 1'b1; bus.wr_req = 2'b11;
        repeat (6) begin
            @(negedge clk);
            chk("full_q_en", bus.q_en, 0);
            chk("full_wr_gnt", bus.wr_gnt, 0);
        end
        force_full = 1'b0;
        wait_en(n);
        chk("full_release_lat", (n <= 2), 1);
        chk("full_release_gnt", bus.wr_gnt, 2'b10);
        bus.wr_req = '0;

        // Empty flag blocks reads.
        repeat (3) @(negedge clk);
        force_empty = 1'b1; bus.rd_req = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("empty_rd_gnt", bus.rd_gnt, 0);
            chk("empty_q_en", bus.q_en, 0);
        end
        bus.rd_req = 1'b0;
        force_empty = 1'b0;

        // Committed decision survives a request dropped right after it.
        repeat (3) @(negedge clk);
        bus.wr_data = 8'h09; bus.wr_req = 2'b01;
        @(posedge clk);
        #1;
        bus.wr_req = '0; bus.wr_data = '0;
        @(negedge clk);
        chk("commit_gnt", bus.wr_gnt, 2'b01);
        chk("commit_din", bus.q_din, 4'b1001);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/queue_access_arbiter.md
Name: queue_access_arbiter

Overview:
- Shares one single-port queue (one operation per cycle: write when q_rw=1, read when q_rw=0) between NP producers and one consumer.
- Producers arbitrate round-robin among themselves; write vs. read is decided by a toggling fairness flag.
- Sequences each queue operation through a three-state FSM so the queue's full/empty flags have settled before the next decision.
- Sits between producer/consumer logic and the queue instance; it is the only master of the queue port.

Parameters:
- DW, 4, data width in bits; matches the queue data width.
- NP, 2, number of producers; legal range 2..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_req  in  NP  per-producer write request (level).
- wr_data  in  NP*DW  producer data; producer i occupies bits [i*DW +: DW].
- wr_gnt  out  NP  one-hot, one-cycle pulse; write of that producer's data is being issued.
- rd_req  in  1  consumer read request (level).
- rd_gnt  out  1  one-cycle pulse; read is being issued.
- rd_valid  out  1  one-cycle pulse; rd_data holds the dequeued word.
- rd_data  out  DW  dequeued word, held until the next rd_valid.
- q_en  out  1  queue operation enable (one-cycle pulse).
- q_rw  out  1  1 = write, 0 = read; meaningful only while q_en=1.
- q_din  out  DW  write data to the queue.
- q_empty  in  1  queue empty flag.
- q_full  in  1  queue full flag.
- q_dout  in  DW  queue read data; valid the cycle after the read operation.

Behaviour:
- Reset (asynchronous, active-high, immediate):
  - All outputs 0, state IDLE.
  - rr_ptr=0, prefer_read=0.
  - Any decision in flight is discarded; no partial grant.
- FSM states are IDLE, ISSUE and SETTLE. All outputs are registered.
- IDLE, evaluated each cycle:
  - A write is eligible when any wr_req bit is 1 and q_full=0.
  - A read is eligible when rd_req=1 and q_empty=0.
  - Write winner: first requesting producer scanning upward from rr_ptr, modulo NP.
  - If both are eligible: read wins when prefer_read=1, else write wins.
  - If exactly one is eligible, it wins.
  - If neither is eligible, stay in IDLE with q_en=0.
  - On a decision: latch op, winner index and wr_data slice, then go to ISSUE.
- ISSUE (exactly one cycle):
  - q_en=1, q_rw=op, q_din=latched data (0 for a read).
  - wr_gnt[winner]=1 for a write, or rd_gnt=1 for a read.
  - Go to SETTLE.
- SETTLE (exactly one cycle):
  - q_en=0.
  - For a read: capture q_dout into rd_data and pulse rd_valid=1.
  - prefer_read becomes 1 after a write and 0 after a read.
  - After a write, rr_ptr becomes (winner+1) mod NP.
  - Go to IDLE.
- Latency: request sampled in IDLE at cycle N → grant at N+1 → rd_valid at N+2. Throughput is one operation per 3 cycles while requests are continuous.
- The decision is committed when latched. A requester that drops its request after the IDLE decision still receives the grant and the operation executes.
- Requesters hold their request and data stable until their grant. After the grant, a request still asserted counts as a new request.
- No overflow or underflow is possible: flags are sampled only in IDLE, after the preceding operation has settled.
- Starvation bound: with continuous contention, each producer is granted within 2*NP operations and the consumer within 2 operations.
- wr_gnt is one-hot or zero. wr_gnt and rd_gnt are never both asserted.

Test Plan:
- Reset then idle: assert reset mid-ISSUE → q_en, wr_gnt, rd_gnt, rd_valid drop to 0 immediately; with no requests, q_en stays 0 for 10 cycles.
- Single write then read, DW=4, empty queue:
  - wr_req=01, wr_data[3:0]=1010 → wr_gnt=01 and q_en=1, q_rw=1, q_din=1010 one cycle after the request.
  - Then rd_req=1 → rd_gnt, then rd_valid=1 with rd_data=1010 one cycle later.
- Round-robin: wr_req=11 held, data 1100/0011, q_full=0 → grants alternate 01,10,01,10 on every third cycle; q_din alternates 1100,0011.
- Read/write fairness: wr_req=01 and rd_req=1 held, queue non-empty and not full → operations alternate write, read, write, read starting with write after reset.
- Boundaries:
  - q_full=1 with wr_req=11 and rd_req=0 → no q_en, no wr_gnt.
  - q_empty=1 with rd_req=1 → no rd_gnt.
  - Deassert q_full → write granted within 2 cycles.
- Committed decision: drop wr_req[0] the cycle after the IDLE decision → wr_gnt[0] still pulses and q_din carries the latched data.
